// File: rtl/alu_slice_card.sv
// Serial ALU card: INC/SUB/ADD/DEC computed SLICEWIDTH bits per falling clock edge.
// A completed result and its carry are published together; flags derive from them only.
module alu_slice_card #(
    parameter int DATAWIDTH  = 16,
    parameter int SLICEWIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATAWIDTH-1:0] data_in,
    input  logic [DATAWIDTH-1:0] addr_in,
    input  logic                 src_sel,
    input  logic [1:0]           ld,
    input  logic [1:0]           op,
    input  logic                 rd,
    output logic [DATAWIDTH-1:0] data_out,
    output logic                 data_oe,
    output logic                 done,
    output logic                 lez,
    output logic                 zero,
    output logic                 neg,
    output logic                 carry
);

    localparam int NSLICE = DATAWIDTH / SLICEWIDTH;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [1:0] OP_INC = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_DEC = 2'b11;

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t                 state_q, state_d;
    logic [DATAWIDTH-1:0]   a_q, a_d;
    logic [DATAWIDTH-1:0]   b_q, b_d;
    logic [1:0]             opl_q, opl_d;
    logic [DATAWIDTH-1:0]   acc_q, acc_d;
    logic                   cy_q, cy_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic [DATAWIDTH-1:0]   result_q, result_d;
    logic                   carry_q, carry_d;

    logic [DATAWIDTH-1:0]   src;
    logic [DATAWIDTH-1:0]   x_op, y_op;
    logic [SLICEWIDTH-1:0]  x_s, y_s;
    logic [SLICEWIDTH:0]    slice_res;

    function automatic logic [SLICEWIDTH:0] slice_add(
        input logic [SLICEWIDTH-1:0] x,
        input logic [SLICEWIDTH-1:0] y,
        input logic                  c
    );
        return {1'b0, x} + {1'b0, y} + {{SLICEWIDTH{1'b0}}, c};
    endfunction

    assign src = src_sel ? data_in : addr_in;

    // Operand mapping: SUB is B + ~A + 1, DEC is A + all-ones with no carry-in.
    always_comb begin
        x_op = a_q;
        y_op = '0;
        case (opl_q)
            OP_INC: begin x_op = a_q; y_op = '0;  end
            OP_SUB: begin x_op = b_q; y_op = ~a_q; end
            OP_ADD: begin x_op = b_q; y_op = a_q; end
            OP_DEC: begin x_op = a_q; y_op = '1;  end
            default: begin x_op = a_q; y_op = '0; end
        endcase
        x_s       = x_op[int'(idx_q)*SLICEWIDTH +: SLICEWIDTH];
        y_s       = y_op[int'(idx_q)*SLICEWIDTH +: SLICEWIDTH];
        slice_res = slice_add(x_s, y_s, cy_q);
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        opl_d    = opl_q;
        acc_d    = acc_q;
        cy_d     = cy_q;
        idx_d    = idx_q;
        result_d = result_q;
        carry_d  = carry_q;

        if (ld != 2'b00) begin
            // A load always wins, aborting any operation in flight.
            a_d     = ld[0] ? src : a_q;
            b_d     = ld[1] ? src : b_q;
            opl_d   = op;
            idx_d   = '0;
            cy_d    = (op == OP_INC) || (op == OP_SUB);
            state_d = CALC;
        end else if (state_q == CALC) begin
            acc_d[int'(idx_q)*SLICEWIDTH +: SLICEWIDTH] = slice_res[SLICEWIDTH-1:0];
            cy_d = slice_res[SLICEWIDTH];
            if (idx_q == IDXW'(NSLICE - 1)) begin
                result_d = acc_d;
                carry_d  = slice_res[SLICEWIDTH];
                state_d  = IDLE;
            end else begin
                idx_d = idx_q + IDXW'(1);
            end
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            opl_q    <= OP_INC;
            acc_q    <= '0;
            cy_q     <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opl_q    <= opl_d;
            acc_q    <= acc_d;
            cy_q     <= cy_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    assign data_out = result_q;
    assign data_oe  = rd;
    assign done     = (state_q == IDLE);
    assign zero     = (result_q == '0);
    assign neg      = result_q[DATAWIDTH-1];
    assign lez      = neg | zero;
    assign carry    = carry_q;

endmodule

// File: doc/alu_slice_card.md
# alu_slice_card

Parametrised successor to the single-operation ALU card on the SUBLEQ backplane. It latches operands A and B from the address or data bus. It computes one of four operations (INC, SUB, ADD, DEC) serially, SLICEWIDTH bits per clock. It reports completion with a done flag and a registered flag set: lez, zero, neg, carry. The sequencer loads operands, waits for done, then enables the result onto the data bus and branches on lez.

## Interface
- DATAWIDTH, default 16: operand/result width.
- SLICEWIDTH, default 4: bits processed per cycle. Must divide DATAWIDTH. NSLICE = DATAWIDTH/SLICEWIDTH.
- clk  in  1  system clock; all state changes on the falling edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  DATAWIDTH  data bus value.
- addr_in  in  DATAWIDTH  address bus value.
- src_sel  in  1  operand source: 1 = data_in, 0 = addr_in.
- ld  in  2  ld[0] loads A, ld[1] loads B. Both may be set together.
- op  in  2  00 INC (A+1), 01 SUB (B−A), 10 ADD (B+A), 11 DEC (A−1).
- rd  in  1  result read enable.
- data_out  out  DATAWIDTH  last completed result.
- data_oe  out  1  bus drive enable (= rd, combinational); the backplane tristates on it.
- done  out  1  high when no operation is pending.
- lez, zero, neg, carry  out  1 each  flags of the last completed result.

## Operation
- Registers:
  - A, B: operand latches.
  - opl: latched op.
  - acc: working result.
  - cy: slice carry.
  - idx: slice counter, 0..NSLICE−1.
  - result: completed result.
  - carry_r: completed carry.
  - state: IDLE or CALC.
- Reset (async, rst_n low):
  - A = B = acc = result = 0; idx = 0; cy = 0; state = IDLE.
  - Outputs: done = 1, data_out = 0, zero = 1, lez = 1, neg = 0, carry = 0.
  - data_oe follows rd at all times.
  - Reset mid-CALC abandons the operation; result stays 0.
- Load, at a falling edge with ld ≠ 00, in any state:
  - Each selected latch takes the src_sel source.
  - opl = op; idx = 0.
  - cy = 1 for INC and SUB, otherwise 0.
  - state = CALC; done = 0.
  - A load during CALC aborts the current operation and restarts with the new operands. The aborted result is never published.
- CALC, each falling edge with ld = 00, for slice s = idx:
  - x = operand X bits of slice s; y = operand Y bits of slice s.
  - {c, sum} = x + y + cy, computed SLICEWIDTH+1 bits wide.
  - acc slice s = sum; cy = c.
  - Operands per op:
    - INC: X = A, Y = 0, initial cy = 1.
    - SUB: X = B, Y = ~A, initial cy = 1.
    - ADD: X = B, Y = A, initial cy = 0.
    - DEC: X = A, Y = all ones, initial cy = 0.
  - If idx = NSLICE−1: result = completed acc (this edge's slice included); carry_r = c; state = IDLE; done = 1. Otherwise idx = idx+1.
- Arithmetic is modulo 2^DATAWIDTH. SUB carry = 1 means no borrow (B ≥ A unsigned).
- Flags are combinational from result and carry_r only. They do not change during CALC.
  - zero = (result == 0).
  - neg = result[DATAWIDTH−1].
  - lez = neg | zero.
  - carry = carry_r.
- IDLE with ld = 00: all registers hold.

## Timing
- Load at falling edge N: done falls after edge N.
- Slices are processed at edges N+1 … N+NSLICE.
- result, flags and done = 1 update together after edge N+NSLICE. Latency is NSLICE cycles (4 at defaults; 1 when SLICEWIDTH = DATAWIDTH).
- Reload at edge M during CALC: completion moves to edge M+NSLICE.
- Back-to-back: a load on the completion edge's successor starts a new operation immediately. There is no dead cycle.
- data_out always reflects result. It is stable while done = 0. rd has zero-cycle effect on data_oe.

## Test plan
- Reset: assert rst_n low mid-CALC. Require immediately: done = 1, data_out = 0x0000, zero = 1, lez = 1, neg = 0, carry = 0. State returns to IDLE.
- SUB: load A = 0x0003, then B = 0x0005 with op = 01 and src_sel = 1. After 4 edges: done = 1, data_out = 0x0002, lez = 0, carry = 1.
- SUB negative: A = 0x0005, B = 0x0003, op = 01. Result = 0xFFFE, neg = 1, lez = 1, carry = 0. The flags hold the previous values until the done edge.
- INC wrap: A = 0xFFFF from addr_in (src_sel = 0, ld = 01), op = 00. Result = 0x0000, zero = 1, lez = 1, carry = 1. Carry must ripple across all four slices.
- Restart: start ADD with A = 0x1111, B = 0x2222. At the 2nd CALC edge, reload with ld = 11, data_in = 0x0800, op = 10. Done rises exactly 4 edges after the reload with result 0x1000. 0x3333 never appears on data_out.
- Single-slice instance (SLICEWIDTH = 16): DEC with A = 0x0000 gives 0xFFFF, carry = 0, neg = 1. Done rises one edge after the load.
